// File: rtl/modsub_sched_pkg.sv
// Shared definitions for the ModSub scheduler slice.
//   sched_state_t : halt/drain FSM encoding (RUN, DRAIN, HALTED)
//   clog2()       : width of a requester index tag, never less than 1 bit
package modsub_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } sched_state_t;

    // A single requester still needs a 1-bit tag so vectors never collapse to zero width.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/modsub_sched_modsub.sv
// ModSub: modular subtraction datapath, M = (A - B) mod q.
// Ports:
//   clk   in  clock, rising edge
//   rstn  in  synchronous reset, active-low; clears the result pipeline
//   A, B  in  operands (BIT_SIZE)
//   q     in  modulus (BIT_SIZE)
//   M     out result, LATENCY cycles after A/B/q are presented
// Operands are expected to be below q; anything else produces whatever the
// wrap-around arithmetic yields.
module ModSub #(
    parameter int BIT_SIZE = 4,
    parameter int LATENCY  = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [BIT_SIZE-1:0] A,
    input  logic [BIT_SIZE-1:0] B,
    input  logic [BIT_SIZE-1:0] q,
    output logic [BIT_SIZE-1:0] M
);

    logic [BIT_SIZE-1:0] diff;
    logic [BIT_SIZE-1:0] stage [LATENCY];

    // When A < B the BIT_SIZE-wide wrap of A-B plus q lands on the right residue,
    // so no extra carry bit is needed.
    always_comb begin
        diff = (A >= B) ? (A - B) : (A - B + q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= diff;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign M = stage[LATENCY-1];

endmodule

// File: rtl/modsub_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports:
//   enable     in  grants allowed this cycle
//   valid      in  per-requester request (NREQ)
//   ptr        in  highest-priority index this cycle
//   grant      out one-hot grant, zero when nothing valid or disabled
//   grant_idx  out index of the granted requester
//   grant_any  out a grant was made
//   ptr_next   out pointer to register: one past the winner, or ptr when idle
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int TW   = 2
) (
    input  logic            enable,
    input  logic [NREQ-1:0] valid,
    input  logic [TW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [TW-1:0]   grant_idx,
    output logic            grant_any,
    output logic [TW-1:0]   ptr_next
);

    int idx;

    // Walk the requesters starting at ptr, wrapping; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        ptr_next  = ptr;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (enable && !grant_any && valid[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = TW'(idx);
                ptr_next       = TW'((idx + 1) % NREQ);
            end
        end
    end

endmodule

// File: rtl/modsub_sched.sv
// modsub_sched: round-robin scheduler sharing one ModSub among NREQ requesters.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous reset, active-high; flushes in-flight ops
//   req_valid  in  per-requester operand valid
//   req_ready  out one-hot grant, transfer on valid & ready
//   req_a/b/q  in  packed operands, requester i at [i*BIT_SIZE +: BIT_SIZE]
//   rsp_valid  out one-hot result strobe to the originating requester
//   rsp_m      out result value, meaningful while rsp_valid is non-zero
//   halt       in  stop issuing and drain
//   halted     out idle with nothing in flight while halt is held
//   busy       out some op is in flight
// Results come back MODSUB_LAT+1 cycles after the handshake: one cycle in
// the operand register plus the ModSub latency. The tag pipe mirrors that.
import modsub_sched_pkg::*;

module modsub_sched #(
    parameter int BIT_SIZE   = 4,
    parameter int NREQ       = 4,
    parameter int MODSUB_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*BIT_SIZE-1:0] req_a,
    input  logic [NREQ*BIT_SIZE-1:0] req_b,
    input  logic [NREQ*BIT_SIZE-1:0] req_q,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [BIT_SIZE-1:0]      rsp_m,
    input  logic                     halt,
    output logic                     halted,
    output logic                     busy
);

    localparam int TW = clog2(NREQ);

    sched_state_t state_q;
    sched_state_t state_d;

    logic                  arb_enable;
    logic [NREQ-1:0]       grant;
    logic [TW-1:0]         grant_idx;
    logic                  grant_any;
    logic [TW-1:0]         ptr_q;
    logic [TW-1:0]         ptr_next;

    logic                  in_vld;
    logic [TW-1:0]         in_idx;
    logic [BIT_SIZE-1:0]   in_a;
    logic [BIT_SIZE-1:0]   in_b;
    logic [BIT_SIZE-1:0]   in_q;

    logic [MODSUB_LAT-1:0] pipe_vld;
    logic [TW-1:0]         pipe_idx [MODSUB_LAT];

    logic [BIT_SIZE-1:0]   modsub_m;

    rr_arbiter #(
        .NREQ (NREQ),
        .TW   (TW)
    ) u_arb (
        .enable    (arb_enable),
        .valid     (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any),
        .ptr_next  (ptr_next)
    );

    assign req_ready = grant;
    assign busy      = in_vld | (|pipe_vld);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants stop the very cycle halt rises, so a drain never has to chase a
    // late issue. halted follows halt directly so it drops as soon as halt does.
    always_comb begin
        state_d    = state_q;
        arb_enable = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_RUN: begin
                arb_enable = !halt && !rst;
                if (halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!halt) begin
                    state_d = ST_RUN;
                end else if (!busy) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                halted = halt;
                if (!halt) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Operand register feeding ModSub plus the tag pipe that tracks who owns
    // each result. Operands only load on issue; the tag valid bits carry meaning.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            in_vld   <= 1'b0;
            in_idx   <= '0;
            in_a     <= '0;
            in_b     <= '0;
            in_q     <= '0;
            pipe_vld <= '0;
            for (int i = 0; i < MODSUB_LAT; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            in_vld <= grant_any;
            if (grant_any) begin
                ptr_q  <= ptr_next;
                in_idx <= grant_idx;
                in_a   <= req_a[int'(grant_idx)*BIT_SIZE +: BIT_SIZE];
                in_b   <= req_b[int'(grant_idx)*BIT_SIZE +: BIT_SIZE];
                in_q   <= req_q[int'(grant_idx)*BIT_SIZE +: BIT_SIZE];
            end
            pipe_vld[0] <= in_vld;
            pipe_idx[0] <= in_idx;
            for (int i = 1; i < MODSUB_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    ModSub #(
        .BIT_SIZE (BIT_SIZE),
        .LATENCY  (MODSUB_LAT)
    ) u_modsub (
        .clk  (clk),
        .rstn (~rst),
        .A    (in_a),
        .B    (in_b),
        .q    (in_q),
        .M    (modsub_m)
    );

    // The last tag stage lines up with ModSub's output, so its index selects
    // which requester sees the strobe.
    always_comb begin
        rsp_valid = '0;
        if (pipe_vld[MODSUB_LAT-1]) begin
            rsp_valid[pipe_idx[MODSUB_LAT-1]] = 1'b1;
        end
    end

    assign rsp_m = modsub_m;

endmodule

// File: tb/tb_modsub_sched.sv
// Directed testbench for modsub_sched (BIT_SIZE=4, NREQ=4, MODSUB_LAT=1).
// Inputs change 1 time unit after the rising edge; outputs are checked one
// unit later, well clear of the next edge.
module tb_modsub_sched;

    localparam int BIT_SIZE   = 4;
    localparam int NREQ       = 4;
    localparam int MODSUB_LAT = 1;

    logic                     clk;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*BIT_SIZE-1:0] req_a;
    logic [NREQ*BIT_SIZE-1:0] req_b;
    logic [NREQ*BIT_SIZE-1:0] req_q;
    logic [NREQ-1:0]          rsp_valid;
    logic [BIT_SIZE-1:0]      rsp_m;
    logic                     halt;
    logic                     halted;
    logic                     busy;

    int checks = 0;
    int errors = 0;

    // Burst table: operands for grant order 0..7 with hand-computed results.
    logic [3:0] tbl_a [8] = '{4'd8, 4'd1, 4'd9,  4'd0, 4'd12, 4'd2,  4'd6, 4'd4};
    logic [3:0] tbl_b [8] = '{4'd3, 4'd6, 4'd9,  4'd4, 4'd2,  4'd10, 4'd5, 4'd14};
    logic [3:0] tbl_q [8] = '{4'd11,4'd7, 4'd13, 4'd5, 4'd13, 4'd11, 4'd7, 4'd15};
    logic [3:0] tbl_m [8] = '{4'd5, 4'd2, 4'd0,  4'd1, 4'd10, 4'd3,  4'd1, 4'd5};

    modsub_sched #(
        .BIT_SIZE   (BIT_SIZE),
        .NREQ       (NREQ),
        .MODSUB_LAT (MODSUB_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_q     (req_q),
        .rsp_valid (rsp_valid),
        .rsp_m     (rsp_m),
        .halt      (halt),
        .halted    (halted),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOperands(input int i, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] q);
        req_a[i*BIT_SIZE +: BIT_SIZE] = a;
        req_b[i*BIT_SIZE +: BIT_SIZE] = b;
        req_q[i*BIT_SIZE +: BIT_SIZE] = q;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic halt_in,
                                 input logic rst_in);
        req_valid = valid;
        halt      = halt_in;
        rst       = rst_in;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        halt      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_q     = '0;

        // 1. Reset for two cycles, then release with nothing requested.
        tick();
        tick();
        checkOutput("rst_ready",  32'(req_ready), 32'h0);
        checkOutput("rst_rspv",   32'(rsp_valid), 32'h0);
        checkOutput("rst_rspm",   32'(rsp_m),     32'h0);
        checkOutput("rst_halted", 32'(halted),    32'h0);
        checkOutput("rst_busy",   32'(busy),      32'h0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("idle_ready", 32'(req_ready), 32'h0);
        checkOutput("idle_busy",  32'(busy),      32'h0);

        // 2. Requester 0: 8-3 mod 11 = 5, two cycles after the handshake.
        tick();
        setOperands(0, 4'd8, 4'd3, 4'd11);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t2_ready", 32'(req_ready), 32'h1);
        checkOutput("t2_rspv0", 32'(rsp_valid), 32'h0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t2_rspv1", 32'(rsp_valid), 32'h0);
        checkOutput("t2_busy",  32'(busy),      32'h1);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t2_rspv2", 32'(rsp_valid), 32'h1);
        checkOutput("t2_rspm",  32'(rsp_m),     32'h5);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t2_rspv3", 32'(rsp_valid), 32'h0);
        checkOutput("t2_idle",  32'(busy),      32'h0);

        // 3. Requester 2 with A<B: 3-8 mod 11 = 6.
        tick();
        setOperands(2, 4'd3, 4'd8, 4'd11);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("t3_ready", 32'(req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t3_rspv", 32'(rsp_valid), 32'h4);
        checkOutput("t3_rspm", 32'(rsp_m),     32'h6);

        // Requester 3 (7-9 mod 13 = 11) moves the pointer around to 0.
        tick();
        setOperands(3, 4'd7, 4'd9, 4'd13);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("t3b_ready", 32'(req_ready), 32'h8);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t3b_rspv", 32'(rsp_valid), 32'h8);
        checkOutput("t3b_rspm", 32'(rsp_m),     32'hB);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // 4. All four valid for 8 cycles: grants rotate, results follow 2 cycles behind.
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c < 8) begin
                for (int i = 0; i < NREQ; i++) begin
                    setOperands(i, tbl_a[(c/4)*4+i], tbl_b[(c/4)*4+i], tbl_q[(c/4)*4+i]);
                end
                applyStimulus(4'b1111, 1'b0, 1'b0);
                checkOutput($sformatf("t4_ready%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
            end else begin
                applyStimulus(4'b0000, 1'b0, 1'b0);
                checkOutput($sformatf("t4_ready%0d", c), 32'(req_ready), 32'h0);
            end
            if (c >= 2) begin
                checkOutput($sformatf("t4_rspv%0d", c), 32'(rsp_valid),
                            32'(1 << ((c - 2) % 4)));
                checkOutput($sformatf("t4_rspm%0d", c), 32'(rsp_m), 32'(tbl_m[c-2]));
            end else begin
                checkOutput($sformatf("t4_rspv%0d", c), 32'(rsp_valid), 32'h0);
            end
        end
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // Single requester held valid is granted every cycle (2+s+3 mod 9 ... = s+3).
        for (int s = 0; s < 5; s++) begin
            tick();
            if (s < 3) begin
                setOperands(2, 4'(s + 5), 4'd2, 4'd9);
                applyStimulus(4'b0100, 1'b0, 1'b0);
                checkOutput($sformatf("single_ready%0d", s), 32'(req_ready), 32'h4);
            end else begin
                applyStimulus(4'b0000, 1'b0, 1'b0);
            end
            if (s >= 2) begin
                checkOutput($sformatf("single_rspv%0d", s), 32'(rsp_valid), 32'h4);
                checkOutput($sformatf("single_rspm%0d", s), 32'(rsp_m), 32'(s + 1));
            end
        end
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // 5. Halt with one op in flight (10-4 mod 11 = 6), then resume.
        tick();
        setOperands(1, 4'd10, 4'd4, 4'd11);
        setOperands(2, 4'd5, 4'd1, 4'd7);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("t5_ready", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("t5_haltready", 32'(req_ready), 32'h0);
        checkOutput("t5_busy1",     32'(busy),      32'h1);
        tick();
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("t5_drainready", 32'(req_ready), 32'h0);
        checkOutput("t5_rspv",       32'(rsp_valid), 32'h2);
        checkOutput("t5_rspm",       32'(rsp_m),     32'h6);
        checkOutput("t5_halted0",    32'(halted),    32'h0);
        tick();
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("t5_busy0",   32'(busy),      32'h0);
        checkOutput("t5_halted1", 32'(halted),    32'h0);
        checkOutput("t5_rspv0",   32'(rsp_valid), 32'h0);
        tick();
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("t5_halted2",  32'(halted),    32'h1);
        checkOutput("t5_hltready", 32'(req_ready), 32'h0);
        tick();
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("t5_unhalt",      32'(halted),    32'h0);
        checkOutput("t5_unhaltready", 32'(req_ready), 32'h0);
        tick();
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("t5_resume", 32'(req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t5_rspv2", 32'(rsp_valid), 32'h4);
        checkOutput("t5_rspm2", 32'(rsp_m),     32'h4);

        // 6. Reset with one op in flight: no response, pointer back at 0.
        //    The pointer sits at 3 here, so this grant also exercises the wrap.
        tick();
        setOperands(0, 4'd9, 4'd2, 4'd11);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t6_wrapready", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("t6_rstready", 32'(req_ready), 32'h0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t6_rspv0", 32'(rsp_valid), 32'h0);
        checkOutput("t6_busy",  32'(busy),      32'h0);
        checkOutput("t6_halted", 32'(halted),   32'h0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t6_rspv1", 32'(rsp_valid), 32'h0);
        tick();
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("t6_ptr", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
